// File: rtl/mem_tile_sram_ctrl.sv
// OBI subordinate driving a grid of single-port SRAM macros. Reads are pipelined
// through the macro latency and land in a credit-protected response FIFO.
module mem_tile_sram_ctrl #(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 512,
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned SramDataWidth = 64,
  parameter int unsigned SramNumWords  = 2048,
  parameter int unsigned NumBankRows   = 4,
  parameter int unsigned SramLatency   = 1,
  parameter int unsigned RspFifoDepth  = 2,
  localparam int unsigned NumBanksPerWord = DataWidth / SramDataWidth,
  localparam int unsigned SramAddrWidth   = $clog2(SramNumWords)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   obi_req_i,
  output logic                                   obi_gnt_o,
  input  logic [AddrWidth-1:0]                   obi_addr_i,
  input  logic                                   obi_we_i,
  input  logic [DataWidth/8-1:0]                 obi_be_i,
  input  logic [DataWidth-1:0]                   obi_wdata_i,
  input  logic [IdWidth-1:0]                     obi_aid_i,
  output logic                                   obi_rvalid_o,
  input  logic                                   obi_rready_i,
  output logic [DataWidth-1:0]                   obi_rdata_o,
  output logic [IdWidth-1:0]                     obi_rid_o,
  output logic                                   obi_err_o,
  output logic [NumBankRows*NumBanksPerWord-1:0] sram_req_o,
  output logic [NumBankRows*NumBanksPerWord-1:0] sram_we_o,
  output logic [SramAddrWidth-1:0]               sram_addr_o,
  output logic [DataWidth-1:0]                   sram_wdata_o,
  output logic [DataWidth/8-1:0]                 sram_be_o,
  input  logic [NumBankRows*DataWidth-1:0]       sram_rdata_i
);

  localparam int unsigned WordOff = $clog2(DataWidth / 8);
  localparam int unsigned RowBits = $clog2(NumBankRows);
  localparam int unsigned RowW    = (RowBits > 0) ? RowBits : 1;
  localparam int unsigned HiBit   = WordOff + SramAddrWidth + RowBits;
  localparam int unsigned OccW    = $clog2(RspFifoDepth + 1);
  localparam int unsigned PtrW    = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
  localparam int unsigned Last    = SramLatency - 1;

  logic [SramAddrWidth-1:0] word;
  logic [RowW-1:0]          row;
  logic                     oor;
  logic                     unused_addr_lsbs;

  assign word             = obi_addr_i[WordOff +: SramAddrWidth];
  assign unused_addr_lsbs = ^obi_addr_i[WordOff-1:0];

  if (RowBits > 0) begin : g_row
    assign row = obi_addr_i[WordOff+SramAddrWidth +: RowBits];
  end else begin : g_no_row
    assign row = '0;
  end

  if (HiBit < AddrWidth) begin : g_oor
    assign oor = |obi_addr_i[AddrWidth-1:HiBit];
  end else begin : g_no_oor
    assign oor = 1'b0;
  end

  // occ counts every granted request not yet popped (pipeline + FIFO)
  logic [OccW-1:0] occ;
  logic            gnt, pop, push;

  assign pop       = obi_rvalid_o && obi_rready_i;
  assign gnt       = !rst_i && obi_req_i && ((occ < OccW'(RspFifoDepth)) || pop);
  assign obi_gnt_o = gnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ <= '0;
    end else if (gnt && !pop) begin
      occ <= occ + 1'b1;
    end else if (!gnt && pop) begin
      occ <= occ - 1'b1;
    end
  end

  always_comb begin
    sram_req_o = '0;
    sram_we_o  = '0;
    for (int unsigned r = 0; r < NumBankRows; r++) begin
      if (gnt && !oor && (row == RowW'(r))) begin
        sram_req_o[r*NumBanksPerWord +: NumBanksPerWord] = '1;
        sram_we_o[r*NumBanksPerWord +: NumBanksPerWord]  = {NumBanksPerWord{obi_we_i}};
      end
    end
  end

  assign sram_addr_o  = word;
  assign sram_wdata_o = obi_wdata_i;
  assign sram_be_o    = obi_be_i;

  logic [SramLatency-1:0] pipe_valid, pipe_we, pipe_err;
  logic [IdWidth-1:0]     pipe_id  [SramLatency];
  logic [RowW-1:0]        pipe_row [SramLatency];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_valid <= '0;
      pipe_we    <= '0;
      pipe_err   <= '0;
      for (int unsigned s = 0; s < SramLatency; s++) begin
        pipe_id[s]  <= '0;
        pipe_row[s] <= '0;
      end
    end else begin
      pipe_valid[0] <= gnt;
      pipe_we[0]    <= obi_we_i;
      pipe_err[0]   <= oor;
      pipe_id[0]    <= obi_aid_i;
      pipe_row[0]   <= row;
      for (int unsigned s = 1; s < SramLatency; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_we[s]    <= pipe_we[s-1];
        pipe_err[s]   <= pipe_err[s-1];
        pipe_id[s]    <= pipe_id[s-1];
        pipe_row[s]   <= pipe_row[s-1];
      end
    end
  end

  logic [DataWidth-1:0] push_rdata;
  assign push       = pipe_valid[Last];
  assign push_rdata = (!pipe_we[Last] && !pipe_err[Last])
                    ? sram_rdata_i[pipe_row[Last]*DataWidth +: DataWidth] : '0;

  logic [DataWidth-1:0]    fifo_rdata [RspFifoDepth];
  logic [IdWidth-1:0]      fifo_rid   [RspFifoDepth];
  logic [RspFifoDepth-1:0] fifo_err;
  logic [PtrW-1:0]         wr_ptr, rd_ptr;
  logic [OccW-1:0]         count;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(RspFifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rdata[wr_ptr] <= push_rdata;
      fifo_rid[wr_ptr]   <= pipe_id[Last];
      fifo_err[wr_ptr]   <= pipe_err[Last];
    end
  end

  assign obi_rvalid_o = (count != '0);
  assign obi_rdata_o  = fifo_rdata[rd_ptr];
  assign obi_rid_o    = fifo_rid[rd_ptr];
  assign obi_err_o    = fifo_err[rd_ptr];

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && (count == OccW'(RspFifoDepth)) && !pop));

endmodule
